executor_row_engine: RTL
========================

Name: executor_row_engine

Overview:
- Parametrised successor to the line-check executor. Operates on the playfield matrix memory through a read/write port pair.
- Two modes:
  - CLEAR: single-pass compaction of all full rows, with zero-fill at the top.
  - RAISE: shifts the whole field up by N rows and inserts N garbage rows at the bottom, with top-out detection.
- Sits between the game controller and the matrix memory. Started after each piece lock (CLEAR) or on a garbage event (RAISE).
- Row 0 is the top row; row height_p-1 is the bottom row.

Parameters:
- width_p, 16, bits per row.
- height_p, 32, number of rows; must be >= 2.
- debug_p, 0, when 1 enables simulation-only state printing; no functional effect.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0=CLEAR, 1=RAISE; captured with start_i.
- raise_n_i  in  CW=$clog2(height_p+1)  rows to raise; captured with start_i; values above height_p are clamped to height_p.
- garbage_row_i  in  width_p  pattern written to each inserted row; captured with start_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse in DONE.
- lines_o  out  CW  rows cleared by the last CLEAR; held until the next accepted start.
- topout_o  out  1  last RAISE pushed a non-zero row off the top; held until the next accepted start.
- mm_read_addr_o  out  AW=$clog2(height_p)  read row address; read data is combinational, same cycle.
- mm_read_data_i  in  width_p  read data.
- mm_write_addr_o  out  AW  write row address.
- mm_write_data_o  out  width_p  write data.
- mm_write_v_o  out  1  write strobe; memory writes on the clock edge.

Behaviour:
- States: IDLE, SCAN, FILL, DONE.
- Reset (asynchronous, any state, including mid-operation): state=IDLE; busy_o=0, done_o=0, mm_write_v_o=0, lines_o=0, topout_o=0; address registers=0. The memory contents may be partially updated; no recovery is attempted.
- IDLE:
  - start_i=1 captures mode_i, clamped raise_n_i and garbage_row_i.
  - Clears lines_o and topout_o.
  - busy_o rises on the following cycle.
  - start_i while busy_o=1 is ignored; it is neither queued nor an error.
- CLEAR mode:
  - SCAN entry: read pointer r=height_p-1, write pointer w=height_p-1.
  - SCAN, each cycle, reads row r:
    - Row full (all ones): no write, lines++.
    - Otherwise: write row r to w (mm_write_v_o=1, including when r==w), then w--.
    - r-- every cycle.
    - After processing r=0, go to FILL; if lines==0, go straight to DONE instead.
  - FILL: write zero to w, w--. After writing row 0, go to DONE. This is exactly lines cycles.
  - Busy duration: height_p + lines + 1 cycles, the +1 being DONE.
- RAISE mode with n = clamped raise_n_i:
  - n==0: go directly from IDLE to DONE; no writes; busy_o is high for 1 cycle.
  - SCAN:
    - r runs 0..height_p-1, one row per cycle.
    - r<n: no write; topout |= (row != 0).
    - r>=n: write row r to r-n.
    - After r=height_p-1, go to FILL.
  - FILL: writes garbage_row_i to rows height_p-n .. height_p-1 in ascending order, then DONE.
  - Busy duration: height_p + n + 1 cycles.
  - n==height_p: SCAN checks every row with no writes, then FILL overwrites the entire field.
- DONE: done_o=1 for exactly one cycle; lines_o and topout_o are final on the same cycle; next state IDLE.
- Outside SCAN-write and FILL, mm_write_v_o=0 and the write address/data are don't-care.
- Counters are CW wide; lines_o never exceeds height_p, so it cannot wrap. Address pointers never go below 0 or above height_p-1.

Test Plan:
- Reset mid-SCAN (drop reset_n_i asynchronously between clock edges) -> outputs go to their reset values immediately; busy_o=0; no write on the next edge.
- CLEAR on an empty field (H=32) -> 32 write strobes, each row r written with its own data at r; lines_o=0; done_o pulses on busy cycle 33.
- CLEAR with rows 31, 29 and 28 full and row 30=0x00F0 -> row 31=0x00F0; rows 0..2=0; lines_o=3; done_o pulses after 32+3+1 cycles.
- CLEAR with all 32 rows full -> no SCAN writes; 32 FILL writes of zero; lines_o=32 (fits CW=6).
- RAISE n=2, garbage=0xFFFE, row 1=0x0100 -> topout_o=1; rows 30..31=0xFFFE; old row k appears at k-2; 35 busy cycles. Repeat with n=0 -> 1 busy cycle, no writes. Repeat with raise_n_i=40 -> clamped to 32, whole field becomes garbage.
- start_i held high throughout an operation, with toggled mode_i -> exactly one operation per IDLE; a new operation is accepted only on the cycle after DONE.

Source files
------------

// File: rtl/executor_row_engine.sv
// executor_row_engine
// Row engine for the playfield matrix memory. Two operations:
//   CLEAR : one bottom-up pass that compacts every non-full row downward,
//           then zero-fills the rows left free at the top.
//   RAISE : one top-down pass that shifts the field up by n rows (noting
//           any non-zero row pushed off the top), then writes the garbage
//           pattern into the n bottom rows.
// Row 0 is the top row, row height_p-1 the bottom row.
//
// Ports
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   start_i, mode_i            start request (IDLE only), 0=CLEAR 1=RAISE
//   raise_n_i, garbage_row_i   RAISE row count (clamped to height_p), pattern
//   busy_o, done_o             busy outside IDLE, one-cycle completion pulse
//   lines_o, topout_o          results of the last operation, held until next start
//   mm_read_addr_o/_data_i     read port, data returns combinationally
//   mm_write_addr_o/_data_o/_v_o  write port, memory writes on the clock edge
module executor_row_engine #(
   parameter int width_p  = 16,
   parameter int height_p = 32,
   parameter int debug_p  = 0,
   localparam int CW = $clog2(height_p + 1),
   localparam int AW = $clog2(height_p)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [CW-1:0]      raise_n_i,
   input  logic [width_p-1:0] garbage_row_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [CW-1:0]      lines_o,
   output logic               topout_o,
   output logic [AW-1:0]      mm_read_addr_o,
   input  logic [width_p-1:0] mm_read_data_i,
   output logic [AW-1:0]      mm_write_addr_o,
   output logic [width_p-1:0] mm_write_data_o,
   output logic               mm_write_v_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [AW-1:0] LAST_ROW = AW'(height_p - 1);

   // State printing is a simulation aid only; the block carries no logic.
   if (debug_p != 0) begin : g_debug
   end

   logic [1:0]         state_q;
   logic               mode_q;
   logic [CW-1:0]      n_q;
   logic [width_p-1:0] garb_q;
   logic [AW-1:0]      r_q, w_q;
   logic [CW-1:0]      lines_q;
   logic               topout_q;

   logic          row_full, row_zero, below_n;
   logic [CW-1:0] n_clamp, lines_nxt;

   assign row_full  = &mm_read_data_i;
   assign row_zero  = ~|mm_read_data_i;
   assign n_clamp   = (raise_n_i > CW'(height_p)) ? CW'(height_p) : raise_n_i;
   assign lines_nxt = lines_q + CW'(row_full);
   // RAISE: rows above n are only inspected for top-out, never moved.
   assign below_n   = CW'(r_q) < n_q;

   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign lines_o        = lines_q;
   assign topout_o       = topout_q;
   assign mm_read_addr_o = r_q;

   always_comb begin
      mm_write_v_o    = 1'b0;
      mm_write_addr_o = w_q;
      mm_write_data_o = '0;
      case (state_q)
         S_SCAN: begin
            mm_write_data_o = mm_read_data_i;
            if (!mode_q) begin
               // Rewrite even when r==w so the pass needs no special case.
               mm_write_v_o = !row_full;
            end else begin
               // Truncation is harmless: with n==height_p no SCAN write occurs.
               mm_write_v_o    = !below_n;
               mm_write_addr_o = r_q - AW'(n_q);
            end
         end
         S_FILL: begin
            mm_write_v_o    = 1'b1;
            mm_write_data_o = mode_q ? garb_q : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= S_IDLE;
         mode_q   <= 1'b0;
         n_q      <= '0;
         garb_q   <= '0;
         r_q      <= '0;
         w_q      <= '0;
         lines_q  <= '0;
         topout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               mode_q   <= mode_i;
               n_q      <= n_clamp;
               garb_q   <= garbage_row_i;
               lines_q  <= '0;
               topout_q <= 1'b0;
               if (mode_i) begin
                  r_q     <= '0;
                  state_q <= (n_clamp == '0) ? S_DONE : S_SCAN;
               end else begin
                  r_q     <= LAST_ROW;
                  w_q     <= LAST_ROW;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!mode_q) begin
                  lines_q <= lines_nxt;
                  // w stops at 0: only reachable when nothing is left to fill.
                  if (!row_full && w_q != '0) w_q <= w_q - 1'b1;
                  if (r_q == '0) state_q <= (lines_nxt == '0) ? S_DONE : S_FILL;
                  else           r_q     <= r_q - 1'b1;
               end else begin
                  if (below_n) topout_q <= topout_q | ~row_zero;
                  if (r_q == LAST_ROW) begin
                     state_q <= S_FILL;
                     w_q     <= AW'(CW'(height_p) - n_q);
                  end else begin
                     r_q <= r_q + 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (!mode_q) begin
                  if (w_q == '0) state_q <= S_DONE;
                  else           w_q     <= w_q - 1'b1;
               end else begin
                  if (w_q == LAST_ROW) state_q <= S_DONE;
                  else                 w_q     <= w_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
